// File: rtl/mem_stage.sv
// Memory-access stage of the single-cycle RV32I core: little-endian byte-addressed
// data memory with funct3-sized loads/stores and the write-back value select.
module mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out,
    input  logic [31:0] dataB,
    input  logic [31:0] instruction,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] read_data,
    output logic [31:0] mem_result
);

    logic [31:0]          mem [DEPTH_WORDS];
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic [2:0]           funct3;
    logic [3:0]           wr_mask;
    logic [31:0]          wr_data;
    logic [31:0]          rd_word;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;
    logic [31:0]          load_val;
    logic                 unused_instr_bits;

    // Upper address bits fall off here, so addresses wrap modulo the memory size.
    assign word_idx = alu_out[ADDR_BITS+1:2];
    assign lane     = alu_out[1:0];
    assign funct3   = instruction[14:12];

    assign unused_instr_bits = ^{instruction[31:15], instruction[11:0]};

    // Replicate store data across lanes; the mask picks which lanes land.
    always_comb begin
        wr_mask = 4'b1111;
        wr_data = dataB;
        case (funct3)
            3'b000: begin
                wr_data = {4{dataB[7:0]}};
                wr_mask = 4'b0001 << lane;
            end
            3'b001: begin
                wr_data = {2{dataB[15:0]}};
                wr_mask = alu_out[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = dataB;
                wr_mask = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[word_idx];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = alu_out[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'h0, rd_byte};
            3'b101:  load_val = {16'h0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    assign read_data  = MemRead ? load_val : 32'h0;
    assign mem_result = MemRead ? read_data : alu_out;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed steps from the test plan followed by random
// loads/stores checked against a flat byte-array model of the memory.
module tb_mem_stage;

    localparam int DEPTH_WORDS = 256;
    localparam int ADDR_BITS   = 8;
    localparam int BYTES       = 4 * DEPTH_WORDS;
    localparam logic [31:0] LW_BASE = 32'h00012183;
    localparam logic [31:0] SW_BASE = 32'h00112023;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] dataB = '0;
    logic [31:0] instruction = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] read_data;
    logic [31:0] mem_result;

    logic [7:0] ref_mem [BYTES];
    int vectors = 0;
    int miscompares = 0;

    mem_stage #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .rst(rst), .alu_out(alu_out), .dataB(dataB),
        .instruction(instruction), .MemRead(MemRead), .MemWrite(MemWrite),
        .read_data(read_data), .mem_result(mem_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [31:0] base, input logic [2:0] f3);
        return {base[31:15], f3, base[11:0]};
    endfunction

    function automatic int unsigned byte_addr(input logic [31:0] a);
        return a % BYTES;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int unsigned ba = byte_addr(a);
        if (f3 == 3'b000) begin
            ref_mem[ba] = d[7:0];
        end else if (f3 == 3'b001) begin
            ref_mem[ba & ~1]     = d[7:0];
            ref_mem[(ba & ~1) + 1] = d[15:8];
        end else begin
            for (int k = 0; k < 4; k++) ref_mem[(ba & ~3) + k] = d[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int unsigned ba = byte_addr(a);
        logic [7:0]  b  = ref_mem[ba];
        logic [15:0] h  = {ref_mem[(ba & ~1) + 1], ref_mem[ba & ~1]};
        logic [31:0] w  = {ref_mem[(ba & ~3) + 3], ref_mem[(ba & ~3) + 2],
                           ref_mem[(ba & ~3) + 1], ref_mem[ba & ~3]};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store occupies one clock edge; the model follows whatever rst says at that edge.
    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        alu_out     = a;
        dataB       = d;
        instruction = mk_instr(SW_BASE, f3);
        MemRead     = 1'b0;
        MemWrite    = 1'b1;
        @(posedge clk);
        if (rst) ref_store(a, d, f3);
        else     ref_clear();
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic check_load(input logic [31:0] a, input logic [2:0] f3,
                              input logic [31:0] exp, input string tag);
        alu_out     = a;
        instruction = mk_instr(LW_BASE, f3);
        MemWrite    = 1'b0;
        MemRead     = 1'b1;
        #1;
        check32({tag, "_rd"}, read_data, exp);
        check32({tag, "_res"}, mem_result, exp);
        MemRead = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_nonmem(input logic [31:0] a, input logic [31:0] instr, input string tag);
        alu_out     = a;
        instruction = instr;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        #1;
        check32({tag, "_rd"}, read_data, 32'h0);
        check32({tag, "_res"}, mem_result, a);
        @(posedge clk);
        #1;
    endtask

    initial begin
        ref_clear();

        // Reset held for two edges, then a load of a cleared word.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_idle_rd", read_data, 32'h0);
        check32("reset_idle_res", mem_result, 32'h0);
        rst = 1'b1;
        check_load(32'd4, 3'b010, 32'h00000000, "reset_lw");

        drive_store(32'd4, 32'hAABBCCDD, 3'b010);
        check_load(32'd4, 3'b010, 32'hAABBCCDD, "sw_lw");

        check_nonmem(32'h00001234, 32'h006282B3, "nonmem");

        check_load(32'd5, 3'b000, 32'hFFFFFFCC, "lb5");
        check_load(32'd5, 3'b100, 32'h000000CC, "lbu5");
        check_load(32'd6, 3'b001, 32'hFFFFAABB, "lh6");
        check_load(32'd4, 3'b101, 32'h0000CCDD, "lhu4");

        drive_store(32'd7, 32'h00000011, 3'b000);
        check_load(32'd4, 3'b010, 32'h11BBCCDD, "sb7_lw");
        drive_store(32'd4, 32'h00002233, 3'b001);
        check_load(32'd4, 3'b010, 32'h11BB2233, "sh4_lw");

        drive_store(BYTES + 8, 32'hDEADBEEF, 3'b010);
        check_load(32'd8, 3'b010, 32'hDEADBEEF, "wrap_lw");

        // Same-cycle read and write: old contents before the edge, new after.
        alu_out     = 32'd12;
        dataB       = 32'h12345678;
        instruction = mk_instr(SW_BASE, 3'b010);
        MemRead     = 1'b1;
        MemWrite    = 1'b1;
        #1;
        check32("raw_before", read_data, 32'h00000000);
        @(posedge clk);
        ref_store(32'd12, 32'h12345678, 3'b010);
        #1;
        check32("raw_after", read_data, 32'h12345678);
        MemWrite = 1'b0;
        MemRead  = 1'b0;

        // Reset on the same edge as a store: store lost, memory cleared.
        rst = 1'b0;
        drive_store(32'd8, 32'hCAFEF00D, 3'b010);
        rst = 1'b1;
        check_load(32'd8, 3'b010, 32'h00000000, "rst_store_lw");
        check_load(32'd4, 3'b010, 32'h00000000, "rst_clear_lw");

        // Random traffic over 16 words with random upper address bits to exercise wrap.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            int unsigned op;
            a  = $urandom() & 32'hFFFF_F03F;
            f3 = 3'($urandom_range(0, 7));
            op = $urandom_range(0, 2);
            if (op == 0)      drive_store(a, $urandom(), f3);
            else if (op == 1) check_load(a, f3, ref_load(a, f3), "rand_load");
            else              check_nonmem(a, $urandom(), "rand_nonmem");
        end

        // Final sweep of the touched region with full-word loads.
        for (int w = 0; w < 16; w++) begin
            check_load(32'(4 * w), 3'b010, ref_load(32'(4 * w), 3'b010), "sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the single-cycle RV32I core; sits between the execute stage (ALU) and write-back.
- Holds a byte-addressable, little-endian data memory.
- Performs loads and stores sized by funct3 of the current instruction.
- Selects the write-back value: load data for loads, otherwise the ALU result.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the data memory (power of two).
- ADDR_BITS, 8, log2(DEPTH_WORDS); word-index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- alu_out  input  32  ALU result: byte address for loads/stores, pass-through value otherwise.
- dataB  input  32  store data (rs2 value).
- instruction  input  32  current instruction; funct3 = instruction[14:12].
- MemRead  input  1  load enable.
- MemWrite  input  1  store enable.
- read_data  output  32  sized and extended load data.
- mem_result  output  32  write-back value.

Behaviour:
- Storage: DEPTH_WORDS x 32-bit array.
  - Word index = alu_out[ADDR_BITS+1:2]; upper address bits ignored, so addresses wrap modulo 4*DEPTH_WORDS.
  - Byte lane = alu_out[1:0]; little-endian (lane 0 = bits 7:0).
- Reset:
  - While rst==0 at a rising edge, every memory word is cleared to 0 and any store is suppressed.
  - Outputs are combinational. During/after reset with no new store, loads return 0 and mem_result follows its normal select rule.
- Store (MemWrite==1, rst==1, rising edge): written in the same cycle.
  - funct3 000 (SB): byte dataB[7:0] to the addressed lane.
  - funct3 001 (SH): dataB[15:0] to lanes {1,0} if alu_out[1]==0, else lanes {3,2}; alu_out[0] ignored.
  - funct3 010 (SW) and any other funct3: full word dataB; alu_out[1:0] ignored.
  - Unwritten lanes keep their value.
- Load (combinational, no latency; MemRead==1): word fetched at the word index, then selected/extended by funct3.
  - 000 LB: addressed byte, sign-extended.
  - 001 LH: halfword (alu_out[1] selects), sign-extended.
  - 100 LBU: addressed byte, zero-extended.
  - 101 LHU: halfword, zero-extended.
  - 010 LW and any other funct3: full word.
- read_data = 0 when MemRead==0.
- mem_result = read_data when MemRead==1, else alu_out. No opcode decode is required; MemRead is authoritative.
- Simultaneous MemRead and MemWrite to the same address in one cycle:
  - read_data shows the pre-write contents until the edge, then the new contents (read-after-write visible next cycle).
- A store written at edge N is readable combinationally from edge N onward.
- Writes with MemWrite==0 never modify memory, regardless of instruction.

Test Plan:
- Reset: hold rst=0 for 2 edges, release, MemRead=1 at address 4 with LW (0x00012183) -> read_data=00000000, mem_result=00000000.
- SW then LW: instruction 0x00112023, alu_out=4, dataB=AABBCCDD, MemWrite=1 for one edge; then MemRead=1, instruction 0x00012183, alu_out=4 -> read_data=AABBCCDD, mem_result=AABBCCDD.
- Non-memory: instruction 0x006282B3, alu_out=00001234, MemRead=MemWrite=0 -> mem_result=00001234, read_data=00000000.
- Byte/half sizing: word 4 holds AABBCCDD.
  - LB at address 5 -> FFFFFFCC; LBU at 5 -> 000000CC.
  - LH at 6 -> FFFFAABB; LHU at 4 -> 0000CCDD.
- Partial store: SB dataB=0x11 at address 7, then LW at 4 -> 11BBCCDD. SH dataB=0x2233 at address 4, then LW -> 11BB2233.
- Wrap/reset mid-operation:
  - SW 0xDEADBEEF at address 4*DEPTH_WORDS+8, then LW at 8 -> DEADBEEF.
  - Assert rst=0 on the same edge as a store -> store suppressed and LW at 8 returns 00000000.
